// File: rtl/stage_1_multi_if.sv
// Handshake and data bundle for stage_1_multi.
// The master side produces float bundles and consumes results, and the slave side is the converter.
interface stage_1_multi_if #(
    parameter int NUM_CH            = 2,
    parameter int FLT_DATA_WIDTH    = 32,
    parameter int CORDIC_DATA_WIDTH = 22
);
    logic                                  in_valid;
    logic                                  in_ready;
    logic [NUM_CH*FLT_DATA_WIDTH-1:0]      x_in;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [NUM_CH*CORDIC_DATA_WIDTH-1:0]   out_fixed;
    logic [NUM_CH*FLT_DATA_WIDTH-1:0]      half_out;
    logic [NUM_CH-1:0]                     ovf;
    logic                                  busy;

    modport master (
        output in_valid, x_in, out_ready,
        input  in_ready, out_valid, out_fixed, half_out, ovf, busy
    );

    modport slave (
        input  in_valid, x_in, out_ready,
        output in_ready, out_valid, out_fixed, half_out, ovf, busy
    );
endinterface

// File: rtl/stage_1_multi.sv
// stage_1_multi: converts a bundle of NUM_CH single-precision floats into signed
// fixed-point values (W bits, F fraction bits), one channel per enabled cycle through
// a single shared datapath. It also produces x/2 for each float and a per-channel
// out-of-range flag.
// Optional feature macro: STAGE1_SATURATE_EN. When it is defined, overflowing channels
// saturate. When it is not defined, they wrap to the low W bits, and Inf/NaN give 0.
module stage_1_multi #(
    parameter int NUM_CH            = 2,
    parameter int FLT_DATA_WIDTH    = 32,
    parameter int CORDIC_DATA_WIDTH = 22,
    parameter int FRAC_BITS         = 19
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_en,
    stage_1_multi_if.slave bus
);
    localparam int W  = CORDIC_DATA_WIDTH;
    localparam int FW = FLT_DATA_WIDTH;
    localparam int CW = $clog2(NUM_CH + 1);
    // Wide enough for a 24-bit mantissa shifted left by up to W-1 places.
    localparam int MW = W + 24;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

`ifdef STAGE1_SATURATE_EN
    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
`endif

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     ch_q, ch_d;
    logic [FW-1:0]     x_q     [NUM_CH];
    logic [W-1:0]      fixed_q [NUM_CH];
    logic [FW-1:0]     half_q  [NUM_CH];
    logic [NUM_CH-1:0] ovf_q;
    logic              accept;
    logic              write_en;

    logic [FW-1:0]     cur_flt;
    logic              f_sign;
    logic [7:0]        f_exp;
    logic [22:0]       f_man;
    int                shift;
    logic [MW-1:0]     mag;
    logic              mag_big;
    logic              mag_ovf;
    logic [W-1:0]      mag_lo;
    logic [W-1:0]      wrap_val;
    logic [W-1:0]      conv_fixed;
    logic              conv_ovf;
    logic [FW-1:0]     conv_half;

    // Next-state logic. The channel counter runs one step past the last channel,
    // so DONE is entered on the cycle after the final write.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        accept   = 1'b0;
        write_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    ch_d    = '0;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (ch_q == CW'(NUM_CH)) begin
                    state_d = S_DONE;
                end else begin
                    write_en = 1'b1;
                    ch_d     = ch_q + CW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Select the channel currently being converted.
    always_comb begin
        cur_flt = x_q[0];
        for (int k = 1; k < NUM_CH; k++) begin
            if (ch_q == CW'(k)) begin
                cur_flt = x_q[k];
            end
        end
    end

    // Shared float-to-fixed datapath. The magnitude is 1.m scaled by 2^(e-127+F) and truncated.
    always_comb begin
        f_sign  = cur_flt[31];
        f_exp   = cur_flt[30:23];
        f_man   = cur_flt[22:0];
        shift   = int'(f_exp) - 150 + FRAC_BITS;
        mag     = '0;
        mag_big = 1'b0;
        if (shift >= W) begin
            // The leading one lands above bit W. The result overflows and the low bits are all zero.
            mag_big = 1'b1;
        end else if (shift >= 0) begin
            mag = MW'({1'b1, f_man}) << shift;
        end else if (shift > -24) begin
            mag = MW'({1'b1, f_man}) >> (-shift);
        end
        mag_ovf  = mag_big | (|mag[MW-1:W-1]);
        mag_lo   = mag[W-1:0];
        wrap_val = f_sign ? (~mag_lo + W'(1)) : mag_lo;

        conv_fixed = wrap_val;
        conv_ovf   = mag_ovf;
        if (f_exp == 8'd0) begin
            conv_fixed = '0;
            conv_ovf   = 1'b0;
        end else if (f_exp == 8'hFF) begin
            conv_ovf = 1'b1;
`ifdef STAGE1_SATURATE_EN
            conv_fixed = ((f_man != 23'd0) || !f_sign) ? SAT_MAX : SAT_MIN;
`else
            conv_fixed = '0;
`endif
        end
`ifdef STAGE1_SATURATE_EN
        else if (mag_ovf) begin
            conv_fixed = f_sign ? SAT_MIN : SAT_MAX;
        end
`endif

        if (f_exp <= 8'd1) begin
            conv_half = {f_sign, 31'd0};
        end else if (f_exp == 8'hFF) begin
            conv_half = cur_flt;
        end else begin
            conv_half = {f_sign, f_exp - 8'd1, f_man};
        end
    end

    // State, input capture and per-channel result registers. Reset overrides clk_en.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            ovf_q   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                x_q[k]     <= '0;
                fixed_q[k] <= '0;
                half_q[k]  <= '0;
            end
        end else if (clk_en) begin
            state_q <= state_d;
            ch_q    <= ch_d;
            for (int k = 0; k < NUM_CH; k++) begin
                if (accept) begin
                    x_q[k] <= bus.x_in[k*FW +: FW];
                end
                if (write_en && (ch_q == CW'(k))) begin
                    fixed_q[k] <= conv_fixed;
                    half_q[k]  <= conv_half;
                    ovf_q[k]   <= conv_ovf;
                end
            end
        end
    end

    logic [NUM_CH*W-1:0]  fixed_pk;
    logic [NUM_CH*FW-1:0] half_pk;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pack
        assign fixed_pk[gi*W +: W]  = fixed_q[gi];
        assign half_pk[gi*FW +: FW] = half_q[gi];
    end

    assign bus.out_fixed = fixed_pk;
    assign bus.half_out  = half_pk;
    assign bus.ovf       = ovf_q;
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_stage_1_multi.sv
// Self-checking bench for stage_1_multi. It applies directed bundles and then random bundles.
// The reference model converts each float with real arithmetic.
module tb_stage_1_multi;
    localparam int NUM_CH = 2;
    localparam int W      = 22;
    localparam int F      = 19;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    int   n_tests = 0;
    int   n_fail  = 0;

    stage_1_multi_if #(.NUM_CH(NUM_CH), .FLT_DATA_WIDTH(32), .CORDIC_DATA_WIDTH(W)) bus ();

    stage_1_multi #(
        .NUM_CH(NUM_CH), .FLT_DATA_WIDTH(32), .CORDIC_DATA_WIDTH(W), .FRAC_BITS(F)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: value = (-1)^s * 1.m * 2^(e-127), scaled by 2^F and truncated toward zero.
    task automatic model(input logic [31:0] f, output logic [W-1:0] fx, output logic ov,
                         output logic [31:0] hf);
        logic s;
        int   e;
        int   m;
        real  mag;
        real  q;
        real  low;
        longint lv;
        longint v;
        s = f[31];
        e = int'(f[30:23]);
        m = int'(f[22:0]);
        if (e == 0) begin
            fx = '0;
            ov = 1'b0;
        end else if (e == 255) begin
            ov = 1'b1;
`ifdef STAGE1_SATURATE_EN
            if (m != 0 || !s) fx = {1'b0, {(W-1){1'b1}}};
            else              fx = {1'b1, {(W-1){1'b0}}};
`else
            fx = '0;
`endif
        end else begin
            mag = (1.0 + real'(m) / 8388608.0) * (2.0 ** real'(e - 127)) * (2.0 ** real'(F));
            ov  = (mag >= 2.0 ** real'(W - 1));
            q   = mag / (2.0 ** real'(W));
            low = $floor((q - $floor(q)) * (2.0 ** real'(W)));
            lv  = longint'(low);
            v   = s ? -lv : lv;
            fx  = v[W-1:0];
`ifdef STAGE1_SATURATE_EN
            if (ov) fx = s ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        end
        if (e <= 1)        hf = {s, 31'd0};
        else if (e == 255) hf = f;
        else               hf = {s, 8'(e - 1), f[22:0]};
    endtask

    function automatic logic [31:0] rand_flt();
        int          sel;
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        sel = int'($urandom_range(0, 9));
        s   = 1'($urandom_range(0, 1));
        m   = 23'($urandom);
        case (sel)
            0:       e = 8'd0;
            1:       e = 8'd1;
            2:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) m = '0; end
            3:       e = 8'($urandom);
            default: e = 8'($urandom_range(110, 132));
        endcase
        return {s, e, m};
    endfunction

    task automatic run_bundle(input logic [NUM_CH*32-1:0] x, input int hold,
                              input int stall_at, input int stall_len, input string name);
        logic [NUM_CH*W-1:0]  ef;
        logic [NUM_CH*32-1:0] eh;
        logic [NUM_CH-1:0]    eo;
        logic [W-1:0]         fx;
        logic                 ov;
        logic [31:0]          hf;
        int                   n;
        for (int k = 0; k < NUM_CH; k++) begin
            model(x[k*32 +: 32], fx, ov, hf);
            ef[k*W +: W]   = fx;
            eh[k*32 +: 32] = hf;
            eo[k]          = ov;
        end
        bus.x_in      = x;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        check({name, ":in_ready_idle"}, 128'(bus.in_ready), 128'(1));
        tick();
        bus.in_valid = 1'b0;
        bus.x_in     = {NUM_CH{32'($urandom)}};
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            if (n == stall_at) begin
                clk_en = 1'b0;
                repeat (stall_len) begin
                    tick();
                    n++;
                end
                clk_en = 1'b1;
            end
            tick();
            n++;
        end
        check({name, ":latency"}, 128'(n), 128'(NUM_CH + 1 + stall_len));
        check({name, ":out_fixed"}, 128'(bus.out_fixed), 128'(ef));
        check({name, ":half_out"}, 128'(bus.half_out), 128'(eh));
        check({name, ":ovf"}, 128'(bus.ovf), 128'(eo));
        check({name, ":in_ready_done"}, 128'(bus.in_ready), 128'(0));
        for (int h = 0; h < hold; h++) begin
            tick();
            check({name, ":hold_valid"}, 128'(bus.out_valid), 128'(1));
            check({name, ":hold_fixed"}, 128'(bus.out_fixed), 128'(ef));
            check({name, ":hold_half"}, 128'(bus.half_out), 128'(eh));
            check({name, ":hold_in_ready"}, 128'(bus.in_ready), 128'(0));
        end
        // Offer a new bundle during the handshake cycle. It must not be taken.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check({name, ":valid_clear"}, 128'(bus.out_valid), 128'(0));
        check({name, ":busy_clear"}, 128'(bus.busy), 128'(0));
        check({name, ":in_ready_back"}, 128'(bus.in_ready), 128'(1));
        $display("[TB] %s x=%h fixed=%h half=%h ovf=%b lat=%0d", name, x, bus.out_fixed,
                 bus.half_out, bus.ovf, n);
    endtask

    initial begin
        logic [W-1:0] exp_sat;
        rst           = 1'b0;
        clk_en        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x_in      = '0;
        repeat (3) tick();
        check("reset:out_valid", 128'(bus.out_valid), 128'(0));
        check("reset:busy", 128'(bus.busy), 128'(0));
        check("reset:out_fixed", 128'(bus.out_fixed), 128'(0));
        check("reset:half_out", 128'(bus.half_out), 128'(0));
        check("reset:ovf", 128'(bus.ovf), 128'(0));
        rst = 1'b1;
        check("reset:in_ready", 128'(bus.in_ready), 128'(1));

        // Basic conversion: 1.0 and -2.5.
        run_bundle({32'hC0200000, 32'h3F800000}, 0, -1, 0, "basic");
        check("basic:const_fixed", 128'(bus.out_fixed), 128'({22'h2C0000, 22'h080000}));
        check("basic:const_half", 128'(bus.half_out), 128'({32'hBFA00000, 32'h3F000000}));
        check("basic:const_ovf", 128'(bus.ovf), 128'(0));

        // 8.0 is out of range for channel 0.
        run_bundle({32'h3F800000, 32'h41000000}, 0, -1, 0, "ovf8");
`ifdef STAGE1_SATURATE_EN
        exp_sat = 22'h1FFFFF;
`else
        exp_sat = 22'h000000;
`endif
        check("ovf8:const_ovf", 128'(bus.ovf), 128'(2'b01));
        check("ovf8:const_fixed0", 128'(bus.out_fixed[W-1:0]), 128'(exp_sat));

        // Zero and a negative denormal.
        run_bundle({32'h80400000, 32'h00000000}, 0, -1, 0, "denorm");
        check("denorm:const_fixed", 128'(bus.out_fixed), 128'(0));
        check("denorm:const_ovf", 128'(bus.ovf), 128'(0));
        check("denorm:const_half", 128'(bus.half_out), 128'({32'h80000000, 32'h00000000}));

        // Downstream stalls for 5 cycles in DONE.
        run_bundle({32'h3FC00000, 32'hBE800000}, 5, -1, 0, "backpressure");

        // clk_en drops for 3 cycles after the first channel has been written.
        run_bundle({32'h40400000, 32'hBF400000}, 0, 1, 3, "clk_en_stall");

        // Reset mid-CONVERT, applied with clk_en low. It must still take effect.
        bus.x_in     = {32'h3F900000, 32'hC0100000};
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst    = 1'b0;
        clk_en = 1'b0;
        tick();
        rst    = 1'b1;
        clk_en = 1'b1;
        check("midrst:out_valid", 128'(bus.out_valid), 128'(0));
        check("midrst:busy", 128'(bus.busy), 128'(0));
        check("midrst:in_ready", 128'(bus.in_ready), 128'(1));
        check("midrst:out_fixed", 128'(bus.out_fixed), 128'(0));
        check("midrst:half_out", 128'(bus.half_out), 128'(0));
        check("midrst:ovf", 128'(bus.ovf), 128'(0));
        repeat (5) tick();
        check("midrst:no_result", 128'(bus.out_valid), 128'(0));
        $display("[TB] midrst aborted bundle, outputs cleared");

        // Random bundles.
        for (int i = 0; i < 40; i++) begin
            logic [NUM_CH*32-1:0] xr;
            int st_at;
            int st_len;
            for (int k = 0; k < NUM_CH; k++) xr[k*32 +: 32] = rand_flt();
            if ($urandom_range(0, 3) == 0) begin
                st_at  = int'($urandom_range(0, NUM_CH));
                st_len = int'($urandom_range(1, 4));
            end else begin
                st_at  = -1;
                st_len = 0;
            end
            run_bundle(xr, int'($urandom_range(0, 2)), st_at, st_len, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stage_1_multi.md
STAGE_1_MULTI -- requirements
Module: stage_1_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of float channels per transaction (1..8).
REQ-002 SHALL have parameter FLT_DATA_WIDTH, default 32, IEEE-754 single-precision input width (fixed).
REQ-003 SHALL have parameter CORDIC_DATA_WIDTH (W), default 22, signed fixed-point output width.
REQ-004 SHALL have parameter FRAC_BITS (F), default 19, fraction bits of fixed-point output.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have port clk_en, input, 1, global enable; low freezes all state and outputs.
REQ-008 SHALL have port in_valid, input, 1, input bundle valid.
REQ-009 SHALL have port in_ready, output, 1, block can accept a bundle.
REQ-010 SHALL have port x_in, input, NUM_CH*32, packed floats; channel k in bits [32k+31:32k].
REQ-011 SHALL have port out_valid, output, 1, result bundle valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-013 SHALL have port out_fixed, output, NUM_CH*W, packed fixed-point conversions.
REQ-014 SHALL have port half_out, output, NUM_CH*32, packed floats equal to x/2.
REQ-015 SHALL have port ovf, output, NUM_CH, per-channel out-of-range flag.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> CONVERT -> DONE -> IDLE; all transitions only when clk_en=1.
REQ-018 SHALL assert in_ready only in IDLE; in IDLE with in_valid=1, register x_in, clear channel counter, go to CONVERT.
REQ-019 SHALL process one channel per enabled cycle in CONVERT through one shared datapath, index 0 upward.
REQ-020 SHALL enter DONE after channel NUM_CH-1 is written; out_valid=1 throughout DONE.
REQ-021 SHALL leave DONE for IDLE on the cycle out_valid=1 and out_ready=1; out_fixed/half_out/ovf hold until next result is written.
REQ-022 SHALL give latency NUM_CH+1 cycles from acceptance edge to out_valid high, with clk_en constantly high.
REQ-023 SHALL not accept a new bundle in the same cycle as a result handshake (in_ready low in DONE).
REQ-024 SHALL convert: value=(-1)^s*1.m*2^(e-127); result = value*2^F truncated toward zero, two's complement, W bits.
REQ-025 SHALL convert exponent 0 (zero/denormal) to 0 with ovf=0.
REQ-026 SHALL set ovf=1 when |value*2^F| >= 2^(W-1) or exponent is 255 (Inf/NaN).
REQ-027 SHALL form half_out: e=0 or e=1 -> signed zero (sign kept); e=255 -> pass through unchanged; else e-1.
REQ-028 SHALL leave clk_en=0 cycles uncounted in latency; handshake inputs are ignored while clk_en=0.

Reset
REQ-029 SHALL, on rst=0 at a rising edge, regardless of clk_en, go to IDLE and clear out_valid, busy, out_fixed, half_out, ovf, and channel counter to 0.
REQ-030 SHALL abort an in-flight bundle on reset mid-CONVERT or mid-DONE with no result produced.
REQ-031 SHALL drive in_ready=1 on the first enabled cycle after rst returns high.

Configuration
REQ-032 SHALL support macro STAGE1_SATURATE_EN selecting overflow handling.
REQ-033 SHALL, with STAGE1_SATURATE_EN defined, saturate an ovf channel to 2^(W-1)-1 (positive) or -2^(W-1) (negative); NaN -> 2^(W-1)-1.
REQ-034 SHALL, with STAGE1_SATURATE_EN undefined, output the low W bits of the truncated result (wrap), Inf/NaN -> 0; ovf still flagged.

Verification
REQ-035 SHALL cover: NUM_CH=2, x_in={0xC0200000,0x3F800000}, out_ready=1 -> out_fixed ch0=0x080000, ch1=0x2C0000, half_out ch0=0x3F000000, ch1=0xBFA00000, ovf=0, out_valid 3 cycles after accept.
REQ-036 SHALL cover: ch0=0x41000000 (8.0) -> ovf[0]=1; out_fixed ch0=0x1FFFFF with STAGE1_SATURATE_EN, 0x000000 without.
REQ-037 SHALL cover: ch0=0x00000000, ch1=0x80400000 (denormal) -> out_fixed 0, ovf 0, half_out 0x00000000 and 0x80000000.
REQ-038 SHALL cover: out_ready low 5 cycles in DONE -> out_valid and outputs stable, in_ready=0; release -> IDLE next cycle.
REQ-039 SHALL cover: clk_en low 3 cycles mid-CONVERT -> out_valid delayed exactly 3 cycles, results unchanged.
REQ-040 SHALL cover: rst=0 one cycle mid-CONVERT -> all outputs 0, no out_valid, in_ready=1 next cycle.
